// File: rtl/matmul_ctrl_pkg.sv
// Shared definitions for the 3x3 matrix-multiply sequencer.
//   DIM      matrix dimension (rows = cols)
//   ELEMS    elements per matrix / results per multiply
//   DW, RW   element and result widths
//   AW, PW   row/col address width and element-pointer width
//   state_e  sequencer states
package matmul_ctrl_pkg;

  localparam int DIM   = 3;
  localparam int ELEMS = DIM * DIM;
  localparam int DW    = 4;
  localparam int RW    = 10;
  localparam int AW    = 2;
  localparam int PW    = 4;

  // Last row/column index and last element pointer, pre-sized for compares.
  localparam logic [AW-1:0] IDX_LAST = AW'(DIM - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(ELEMS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD_W,
    S_LOAD_X,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/matmul_res_buf.sv
// Result buffer: nine RW-bit entries written once per CAPTURE cycle and read
// back in the same order during DRAIN.
//   clk, rst    clock and synchronous active-high reset (pointers only)
//   ptr_clr_i   return both pointers to entry 0
//   we_i        write wdata_i at wr_ptr, then advance wr_ptr
//   wdata_i     result from the datapath
//   rd_adv_i    current read entry consumed, advance rd_ptr
//   wr_ptr_o    next entry to be written
//   rd_ptr_o    entry currently presented on rdata_o
//   rdata_o     combinational read of entry rd_ptr
module matmul_res_buf
  import matmul_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ptr_clr_i,
  input  logic          we_i,
  input  logic [RW-1:0] wdata_i,
  input  logic          rd_adv_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [RW-1:0] rdata_o
);

  logic [RW-1:0] mem_q [ELEMS];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Pointers wrap back to 0 after the last entry so they never leave 0..8.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (ptr_clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (we_i) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_adv_i) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign rdata_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for the 3x3 matrix-multiply datapath. Loads W then X from the
// host stream into the datapath memory bank, waits the fixed compute latency,
// captures the nine results and drains them to the host with backpressure.
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin one multiply (sampled only in IDLE)
//   busy, done               activity flag, one-cycle completion pulse
//   in_data/valid/ready      host element stream, row-major, all W then all X
//   dp_data_in               copy of in_data to the datapath
//   dp_clear_mem             datapath memory clear (one cycle)
//   dp_row_w/col_w, dp_we_w  W write address and strobe
//   dp_row_x/col_x, dp_we_x  X write address and strobe
//   dp_data_out              datapath result stream
//   res_data/valid/ready     result stream to host, row-major
module matmul_ctrl
  import matmul_ctrl_pkg::*;
#(
  parameter int RES_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] dp_data_in,
  output logic          dp_clear_mem,
  output logic [AW-1:0] dp_row_w,
  output logic [AW-1:0] dp_col_w,
  output logic [AW-1:0] dp_row_x,
  output logic [AW-1:0] dp_col_x,
  output logic          dp_we_w,
  output logic          dp_we_x,
  input  logic [RW-1:0] dp_data_out,
  output logic [RW-1:0] res_data,
  output logic          res_valid,
  input  logic          res_ready
);

  state_e        state_q;
  logic          busy_q;
  logic          done_q;
  logic          in_ready_q;
  logic          clear_q;
  logic          res_valid_q;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic [7:0]    lat_q;

  logic          accept;
  logic          last_beat;
  logic          cap_we;
  logic          rd_adv;
  logic          ptr_clr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [RW-1:0] buf_rdata;

  // in_ready_q is only ever high in the two load states.
  assign accept    = in_valid & in_ready_q;
  assign last_beat = (row_q == IDX_LAST) && (col_q == IDX_LAST);

  // Row-major walk: column first, wrapping into the next row.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == IDX_LAST) begin
      col_d = '0;
      row_d = row_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      clear_q     <= 1'b0;
      res_valid_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      lat_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            clear_q <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
          end
        end
        S_CLEAR: begin
          state_q    <= S_LOAD_W;
          in_ready_q <= 1'b1;
          row_q      <= '0;
          col_q      <= '0;
        end
        S_LOAD_W: begin
          if (accept) begin
            if (last_beat) begin
              state_q <= S_LOAD_X;
              row_q   <= '0;
              col_q   <= '0;
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        S_LOAD_X: begin
          if (accept) begin
            if (last_beat) begin
              in_ready_q <= 1'b0;
              row_q      <= '0;
              col_q      <= '0;
              // lat_q counts the cycles still to go before the first result;
              // with a latency of one the first result arrives right away.
              if (RES_LAT <= 1) begin
                state_q <= S_CAPTURE;
              end else begin
                state_q <= S_WAIT;
                lat_q   <= 8'(RES_LAT - 1);
              end
            end else begin
              row_q <= row_d;
              col_q <= col_d;
            end
          end
        end
        S_WAIT: begin
          // Leaving as the count hits zero puts the first CAPTURE cycle
          // exactly RES_LAT cycles after the last X strobe.
          if (lat_q <= 8'd1) begin
            state_q <= S_CAPTURE;
            lat_q   <= '0;
          end else begin
            lat_q <= lat_q - 8'd1;
          end
        end
        S_CAPTURE: begin
          if (wr_ptr == PTR_LAST) begin
            state_q     <= S_DRAIN;
            res_valid_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (res_ready && (rd_ptr == PTR_LAST)) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The datapath cannot stall, so capture is unconditional in CAPTURE.
  assign cap_we  = (state_q == S_CAPTURE);
  assign rd_adv  = res_valid_q & res_ready;
  assign ptr_clr = (state_q == S_IDLE);

  matmul_res_buf u_res_buf (
    .clk      (clk),
    .rst      (rst),
    .ptr_clr_i(ptr_clr),
    .we_i     (cap_we),
    .wdata_i  (dp_data_out),
    .rd_adv_i (rd_adv),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .rdata_o  (buf_rdata)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign in_ready     = in_ready_q;
  assign dp_clear_mem = clear_q;
  assign dp_data_in   = in_data;
  // Strobes and addresses are qualified by the load state so the inactive
  // matrix always sees address 0 and no write.
  assign dp_we_w      = accept && (state_q == S_LOAD_W);
  assign dp_we_x      = accept && (state_q == S_LOAD_X);
  assign dp_row_w     = (state_q == S_LOAD_W) ? row_q : '0;
  assign dp_col_w     = (state_q == S_LOAD_W) ? col_q : '0;
  assign dp_row_x     = (state_q == S_LOAD_X) ? row_q : '0;
  assign dp_col_x     = (state_q == S_LOAD_X) ? col_q : '0;
  assign res_valid    = res_valid_q;
  // Buffer entries are unreset, so hide them outside DRAIN.
  assign res_data     = res_valid_q ? buf_rdata : '0;

endmodule

// File: tb/tb_matmul_ctrl.sv
module tb_matmul_ctrl;

  logic clk;
  logic rst;
  logic rst1;
  logic start;
  logic in_valid;
  logic res_ready;
  logic [3:0] in_data;

  logic [1:0] busy, done, in_ready, clr, we_w, we_x, res_valid;
  logic [1:0][3:0] dpi;
  logic [1:0][1:0] row_w, col_w, row_x, col_x;
  logic [1:0][9:0] res_data;
  logic [1:0][9:0] dpo = '0;

  // Instance 0 uses RES_LAT=4, instance 1 uses RES_LAT=1 and is held in
  // reset except during the latency test.
  matmul_ctrl #(.RES_LAT(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .done(done[0]),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
    .dp_data_in(dpi[0]), .dp_clear_mem(clr[0]),
    .dp_row_w(row_w[0]), .dp_col_w(col_w[0]), .dp_row_x(row_x[0]), .dp_col_x(col_x[0]),
    .dp_we_w(we_w[0]), .dp_we_x(we_x[0]), .dp_data_out(dpo[0]),
    .res_data(res_data[0]), .res_valid(res_valid[0]), .res_ready(res_ready)
  );

  matmul_ctrl #(.RES_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start), .busy(busy[1]), .done(done[1]),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
    .dp_data_in(dpi[1]), .dp_clear_mem(clr[1]),
    .dp_row_w(row_w[1]), .dp_col_w(col_w[1]), .dp_row_x(row_x[1]), .dp_col_x(col_x[1]),
    .dp_we_w(we_w[1]), .dp_we_x(we_x[1]), .dp_data_out(dpo[1]),
    .res_data(res_data[1]), .res_valid(res_valid[1]), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  // Memories are written from the strobes; results appear on dp_data_out
  // for nine cycles starting LAT cycles after the last X strobe, otherwise
  // a marker value (999) that can never be a valid product.
  logic [3:0] wm [2][9];
  logic [3:0] xm [2][9];
  int mcnt [2] = '{0, 0};
  bit mrun [2] = '{1'b0, 1'b0};

  function automatic logic [9:0] dp_res(input int i, input int k);
    int s;
    int r;
    int c;
    s = 0;
    r = k / 3;
    c = k % 3;
    for (int j = 0; j < 3; j++) s += int'(wm[i][r*3+j]) * int'(xm[i][j*3+c]);
    return 10'(s);
  endfunction

  function automatic int next_cnt(input int i);
    if (we_x[i]) return 0;
    if (mrun[i] && mcnt[i] < 1000) return mcnt[i] + 1;
    return mcnt[i];
  endfunction

  function automatic bit next_run(input int i);
    if (we_x[i]) return 1'b1;
    if (clr[i]) return 1'b0;
    return mrun[i];
  endfunction

  function automatic logic [9:0] model_out(input int i);
    int nc;
    int lat;
    nc  = next_cnt(i);
    lat = (i == 0) ? 4 : 1;
    if (next_run(i) && nc >= lat && nc < lat + 9) return dp_res(i, nc - lat);
    return 10'd999;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        for (int j = 0; j < 9; j++) begin
          wm[i][j] <= 4'd0;
          xm[i][j] <= 4'd0;
        end
      end
      if (we_w[i] && (int'(row_w[i]) * 3 + int'(col_w[i])) < 9)
        wm[i][int'(row_w[i]) * 3 + int'(col_w[i])] <= dpi[i];
      if (we_x[i] && (int'(row_x[i]) * 3 + int'(col_x[i])) < 9)
        xm[i][int'(row_x[i]) * 3 + int'(col_x[i])] <= dpi[i];
      mcnt[i] <= next_cnt(i);
      mrun[i] <= next_run(i);
      dpo[i]  <= model_out(i);
    end
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] stim [18];
  logic [9:0] res0 [16];
  logic [9:0] res1 [16];
  int n_res0, n_res1, n_done0, n_done1, n_wew, n_wex, n_clr, n_busy0, n_busy1;
  int gap_err, addr_err, stall_err, res_at_done;
  bit timeout;

  task automatic load_identity();
    for (int k = 0; k < 9; k++) stim[k] = (k / 3 == k % 3) ? 4'd1 : 4'd0;
    for (int k = 0; k < 9; k++) stim[9+k] = 4'(k + 1);
  endtask

  task automatic load_all15();
    for (int k = 0; k < 18; k++) stim[k] = 4'd15;
  endtask

  // Runs one multiply. vmode 1 = in_valid pattern 1,0,0,1; rmode 1 = res_ready
  // low five result cycles then alternating; glitch = extra start pulses in
  // LOAD_X and DRAIN; rst_at 1/2 = reset mid LOAD_W / mid DRAIN and return.
  task automatic run_op(input int vmode, input int rmode, input int glitch, input int rst_at);
    int idx, rcnt, vcyc, post;
    bit prev_stall, stop, g1, g2, rst_hit;
    logic [9:0] prev_data;
    n_res0 = 0; n_res1 = 0; n_done0 = 0; n_done1 = 0; n_wew = 0; n_wex = 0;
    n_clr = 0; n_busy0 = 0; n_busy1 = 0; gap_err = 0; addr_err = 0; stall_err = 0;
    res_at_done = -1; timeout = 1'b0;
    idx = 0; rcnt = 0; vcyc = 0; post = -1; prev_stall = 1'b0; stop = 1'b0;
    g1 = 1'b0; g2 = 1'b0; rst_hit = 1'b0; prev_data = '0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; res_ready = (rmode == 0);
    for (int cyc = 0; cyc < 500 && !stop; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (glitch != 0 && idx == 12 && !g1) begin start = 1'b1; g1 = 1'b1; end
      if (glitch != 0 && n_res0 == 2 && !g2) begin start = 1'b1; g2 = 1'b1; end
      in_valid = (idx < 18) && (vmode == 0 || vcyc % 4 == 0 || vcyc % 4 == 3);
      in_data  = stim[(idx < 18) ? idx : 0];
      vcyc++;
      res_ready = (rmode == 0) ? 1'b1 : (rcnt >= 5 && rcnt % 2 == 1);
      if ((rst_at == 1 && idx == 4) || (rst_at == 2 && n_res0 == 3)) begin
        rst = 1'b1;
        rst_hit = 1'b1;
      end
      @(negedge clk);
      if ((we_w[0] || we_x[0]) && !in_valid) gap_err++;
      n_wew   += int'(we_w[0]);
      n_wex   += int'(we_x[0]);
      n_clr   += int'(clr[0]);
      n_busy0 += int'(busy[0]);
      n_busy1 += int'(busy[1]);
      if (in_valid && in_ready[0]) begin
        if (idx < 9) begin
          if (!(we_w[0] && !we_x[0] && row_w[0] == 2'(idx / 3) && col_w[0] == 2'(idx % 3)
                && row_x[0] == 2'd0 && col_x[0] == 2'd0 && dpi[0] == in_data)) addr_err++;
        end else begin
          if (!(we_x[0] && !we_w[0] && row_x[0] == 2'((idx - 9) / 3) && col_x[0] == 2'((idx - 9) % 3)
                && row_w[0] == 2'd0 && col_w[0] == 2'd0 && dpi[0] == in_data)) addr_err++;
        end
        idx++;
      end
      if (res_valid[0]) begin
        if (prev_stall && res_data[0] !== prev_data) stall_err++;
        if (res_ready) begin
          if (n_res0 < 16) res0[n_res0] = res_data[0];
          n_res0++;
        end
        prev_stall = !res_ready;
        prev_data  = res_data[0];
        rcnt++;
      end else begin
        if (prev_stall) stall_err++;
        prev_stall = 1'b0;
      end
      if (res_valid[1] && res_ready) begin
        if (n_res1 < 16) res1[n_res1] = res_data[1];
        n_res1++;
      end
      if (done[0]) begin
        n_done0++;
        if (n_done0 == 1) res_at_done = n_res0;
      end
      if (done[1]) n_done1++;
      if (rst_hit) break;
      if (post > 0) begin
        post--;
        if (post == 0 && (rst1 || n_done1 > 0)) stop = 1'b1;
      end else if (n_done0 > 0 && post < 0) begin
        post = 3;
      end
    end
    if (rst_hit) begin
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b1; res_ready = 1'b1; start = 1'b0;
      @(negedge clk);
    end else begin
      if (!stop) timeout = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; start = 1'b0;
    end
    $display("op vmode=%0d rmode=%0d glitch=%0d rst_at=%0d: results=%0d done=%0d we_w=%0d we_x=%0d busy_cycles=%0d",
             vmode, rmode, glitch, rst_at, n_res0, n_done0, n_wew, n_wex, n_busy0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; res_ready = 1'b1; start = 1'b0; in_data = 4'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy[0], done[0], in_ready[0], clr[0], we_w[0], we_x[0], res_valid[0]} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {busy[0], done[0], in_ready[0], clr[0], we_w[0], we_x[0], res_valid[0]});
    end
    n_checks++;
    if (res_data[0] !== 10'd0) begin
      n_fail++; $display("FAIL reset_res_data: got %0d expected 0", res_data[0]);
    end
    n_checks++;
    if ({row_w[0], col_w[0], row_x[0], col_x[0]} !== 8'd0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 00", {row_w[0], col_w[0], row_x[0], col_x[0]});
    end
    n_checks++;
    if (dpi[0] !== 4'd7) begin
      n_fail++; $display("FAIL reset_data_copy: got %0d expected 7", dpi[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start_busy: got %b expected 0", busy[0]);
    end
  endtask

  task automatic test_identity();
    load_identity();
    run_op(0, 0, 0, 0);
    n_checks++;
    if (timeout || n_res0 !== 9) begin
      n_fail++; $display("FAIL ident_count: got %0d results timeout=%0d expected 9", n_res0, timeout);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (res0[k] !== 10'(k + 1)) begin
        n_fail++; $display("FAIL ident_res[%0d]: got %0d expected %0d", k, res0[k], k + 1);
      end
    end
    n_checks++;
    if (n_done0 !== 1) begin n_fail++; $display("FAIL ident_done: got %0d pulses expected 1", n_done0); end
    n_checks++;
    if (n_wew !== 9 || n_wex !== 9) begin
      n_fail++; $display("FAIL ident_strobes: got w=%0d x=%0d expected 9/9", n_wew, n_wex);
    end
    n_checks++;
    if (n_clr !== 1) begin n_fail++; $display("FAIL ident_clear: got %0d cycles expected 1", n_clr); end
    n_checks++;
    if (n_busy0 !== 40) begin n_fail++; $display("FAIL ident_busy: got %0d cycles expected 40", n_busy0); end
    n_checks++;
    if (addr_err !== 0 || gap_err !== 0) begin
      n_fail++; $display("FAIL ident_addr: got addr_err=%0d gap_err=%0d expected 0/0", addr_err, gap_err);
    end
  endtask

  task automatic test_latency();
    load_all15();
    @(posedge clk); #1;
    rst1 = 1'b0;
    run_op(0, 0, 0, 0);
    n_checks++;
    if (timeout || n_res0 !== 9 || n_res1 !== 9) begin
      n_fail++; $display("FAIL lat_count: got %0d/%0d results expected 9/9", n_res0, n_res1);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (res0[k] !== 10'd675) begin
        n_fail++; $display("FAIL lat4_res[%0d]: got %0d expected 675", k, res0[k]);
      end
      n_checks++;
      if (res1[k] !== 10'd675) begin
        n_fail++; $display("FAIL lat1_res[%0d]: got %0d expected 675", k, res1[k]);
      end
    end
    n_checks++;
    if (n_busy0 !== 40 || n_busy1 !== 37) begin
      n_fail++; $display("FAIL lat_busy: got %0d/%0d cycles expected 40/37", n_busy0, n_busy1);
    end
    n_checks++;
    if (n_done1 !== 1) begin n_fail++; $display("FAIL lat1_done: got %0d expected 1", n_done1); end
    @(posedge clk); #1;
    rst1 = 1'b1;
  endtask

  task automatic test_gaps();
    load_identity();
    run_op(1, 0, 0, 0);
    n_checks++;
    if (timeout || n_res0 !== 9) begin
      n_fail++; $display("FAIL gaps_count: got %0d results expected 9", n_res0);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (res0[k] !== 10'(k + 1)) begin
        n_fail++; $display("FAIL gaps_res[%0d]: got %0d expected %0d", k, res0[k], k + 1);
      end
    end
    n_checks++;
    if (gap_err !== 0) begin n_fail++; $display("FAIL gaps_strobe: got %0d gap strobes expected 0", gap_err); end
    n_checks++;
    if (addr_err !== 0) begin n_fail++; $display("FAIL gaps_addr: got %0d address errors expected 0", addr_err); end
    n_checks++;
    if (n_wew + n_wex !== 18) begin n_fail++; $display("FAIL gaps_strobes: got %0d expected 18", n_wew + n_wex); end
  endtask

  task automatic test_backpressure();
    load_identity();
    run_op(0, 1, 0, 0);
    n_checks++;
    if (timeout || n_res0 !== 9) begin
      n_fail++; $display("FAIL bp_count: got %0d results expected 9", n_res0);
    end
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (res0[k] !== 10'(k + 1)) begin
        n_fail++; $display("FAIL bp_res[%0d]: got %0d expected %0d", k, res0[k], k + 1);
      end
    end
    n_checks++;
    if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
    n_checks++;
    if (n_done0 !== 1 || res_at_done !== 9) begin
      n_fail++; $display("FAIL bp_done: got %0d pulses after %0d results expected 1 after 9", n_done0, res_at_done);
    end
  endtask

  task automatic test_start_ignored();
    load_all15();
    run_op(0, 0, 1, 0);
    n_checks++;
    if (timeout || n_res0 !== 9 || n_done0 !== 1) begin
      n_fail++; $display("FAIL glitch_count: got %0d results %0d done expected 9 and 1", n_res0, n_done0);
    end
    n_checks++;
    if (res0[0] !== 10'd675 || res0[8] !== 10'd675) begin
      n_fail++; $display("FAIL glitch_res: got %0d,%0d expected 675,675", res0[0], res0[8]);
    end
    n_checks++;
    if (n_busy0 !== 40) begin n_fail++; $display("FAIL glitch_busy: got %0d expected 40", n_busy0); end
  endtask

  task automatic test_reset_mid();
    load_identity();
    run_op(0, 0, 0, 1);
    n_checks++;
    if ({busy[0], done[0], in_ready[0], clr[0], we_w[0], we_x[0], res_valid[0]} !== 7'd0 ||
        {row_w[0], col_w[0], row_x[0], col_x[0]} !== 8'd0) begin
      n_fail++; $display("FAIL rst_loadw: got flags=%b addr=%h expected 0/0",
        {busy[0], done[0], in_ready[0], clr[0], we_w[0], we_x[0], res_valid[0]},
        {row_w[0], col_w[0], row_x[0], col_x[0]});
    end
    run_op(0, 0, 0, 0);
    n_checks++;
    if (timeout || n_res0 !== 9 || res0[4] !== 10'd5 || res0[8] !== 10'd9) begin
      n_fail++; $display("FAIL rst_loadw_rerun: got %0d results r4=%0d r8=%0d expected 9, 5, 9", n_res0, res0[4], res0[8]);
    end
    run_op(0, 0, 0, 2);
    n_checks++;
    if ({busy[0], done[0], in_ready[0], res_valid[0]} !== 4'd0 || res_data[0] !== 10'd0) begin
      n_fail++; $display("FAIL rst_drain: got flags=%b data=%0d expected 0/0",
        {busy[0], done[0], in_ready[0], res_valid[0]}, res_data[0]);
    end
    load_all15();
    run_op(0, 0, 0, 0);
    n_checks++;
    if (timeout || n_res0 !== 9 || res0[0] !== 10'd675 || res0[8] !== 10'd675 || n_done0 !== 1) begin
      n_fail++; $display("FAIL rst_drain_rerun: got %0d results r0=%0d r8=%0d done=%0d expected 9, 675, 675, 1",
        n_res0, res0[0], res0[8], n_done0);
    end
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0; res_ready = 1'b0;
    test_reset();
    test_identity();
    test_latency();
    test_gaps();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_ctrl.md
Name: matmul_ctrl

Overview:
- Sequencer for the 3x3 matrix-multiply datapath.
- Accepts a start command, then streams 9 W elements and 9 X elements from a host valid/ready interface into the datapath memory bank, generating row/column addresses and write strobes.
- Waits a fixed compute latency, captures the 9 results the datapath emits on consecutive cycles, and drains them to the host through a valid/ready result port with backpressure.

Parameters:
- DIM, 3, matrix dimension (rows = cols); address fields are 2 bits.
- DW, 4, element width.
- RW, 10, result width.
- RES_LAT, 4, cycles from the last X write strobe to the first valid result on dp_data_out.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one multiply; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the 9th result is accepted.
- in_data  in  DW  host element, row-major, all W then all X.
- in_valid  in  1  host element valid.
- in_ready  out  1  controller accepts an element this cycle.
- dp_data_in  out  DW  to datapath data_in; combinational copy of in_data.
- dp_clear_mem  out  1  to datapath clear_mem.
- dp_row_w, dp_col_w  out  2 each  W write address.
- dp_row_x, dp_col_x  out  2 each  X write address.
- dp_we_w, dp_we_x  out  1 each  memory-bank write strobes for W and X.
- dp_data_out  in  RW  datapath result.
- res_data  out  RW  result to host, row-major order.
- res_valid  out  1  res_data valid.
- res_ready  in  1  host accepts the result.

Behaviour:
- Reset: state IDLE. busy, done, in_ready, dp_clear_mem, dp_we_w, dp_we_x, res_valid = 0. All address counters = 0; all read/write pointers = 0; res_data = 0. Reset mid-operation aborts immediately; buffer contents are don't-care.
- States: IDLE, CLEAR, LOAD_W, LOAD_X, WAIT, CAPTURE, DRAIN.
- IDLE: when start=1, go to CLEAR. start in any other state is ignored.
- CLEAR: exactly 1 cycle with dp_clear_mem=1, then LOAD_W. Row/col counters reset to 0.
- LOAD_W:
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - Accepted beat: dp_we_w=1 in the same cycle; dp_row_w/dp_col_w = current counters; dp_data_in = in_data.
  - After each beat, col increments; col wraps 2->0 with row incrementing.
  - After beat (2,2), go to LOAD_X with counters = 0.
  - in_valid gaps stall without strobes.
- LOAD_X: identical, using dp_we_x and dp_row_x/dp_col_x. After beat (2,2), go to WAIT.
- Address outputs for the inactive matrix hold 0. Write strobes are never high outside their load state.
- WAIT: counter loads RES_LAT-1 on entry, decrements to 0, then go to CAPTURE. The first CAPTURE cycle is therefore exactly RES_LAT cycles after the last dp_we_x.
- CAPTURE: 9 consecutive cycles; buffer[wr_ptr] <= dp_data_out, wr_ptr 0..8. After wr_ptr=8, go to DRAIN. No host backpressure is applied here, because the datapath cannot stall.
- DRAIN:
  - res_valid=1, res_data=buffer[rd_ptr].
  - On res_valid & res_ready, rd_ptr increments.
  - On acceptance at rd_ptr=8: res_valid drops next cycle, done=1 for one cycle, state returns to IDLE.
  - res_data must stay stable while res_valid=1 and res_ready=0.
- busy asserts the cycle after start is sampled and deasserts in the same cycle done pulses.
- Width: results are unsigned RW bits. The maximum 3*15*15 = 675 fits, so there is no saturation logic.
- Element counters never exceed 8; no other wrap-around condition exists.

Decomposition:
- Package matmul_ctrl_pkg: state enum, DIM, ELEMS=DIM*DIM, DW, RW, address width 2.
- Sub-module matmul_res_buf: 9 x RW register file with write port (we, wr_ptr, wdata), read port (rd_ptr, rdata), and pointer logic.
- FSM, address counters and latency counter stay in matmul_ctrl.

Test Plan:
- W = identity, X = 1..9 with in_valid held high, res_ready held high -> results 1,2,...,9 in order; done pulses once; 18 write strobes total; dp_clear_mem high for exactly 1 cycle.
- W and X all 15 -> nine results of 675; first CAPTURE cycle exactly RES_LAT cycles after the last dp_we_x (checked with RES_LAT=4 and RES_LAT=1).
- in_valid toggling 1,0,0,1 during loads -> no strobes on gap cycles; addresses advance only on accepted beats; results identical to the first scenario.
- res_ready low for 5 cycles, then alternating -> res_data stable while stalled; no result lost or duplicated; done only after the 9th acceptance.
- start pulsed during LOAD_X and during DRAIN -> ignored; sequence completes normally with exactly one done.
- rst asserted mid LOAD_W and mid DRAIN -> next cycle IDLE with all outputs 0; a fresh start then yields the correct 9 results.
